// File: rtl/ice_echo_int_if.sv
// ICE internal bus bundle seen by the echo responder.
//   ma_*            master frame (message type, payload strobe, frame envelope)
//   sl_overflow     controller TX buffer full
//   sl_tail         controller TX buffer tail (first free entry)
//   sl_arb_grant    slave-bus grant for this slot
//   sl_arb_request  slave-bus request
//   sl_addr/sl_data TX buffer write port, sl_data = {write_enable, byte}
//   sl_latch_tail   one-cycle commit of sl_addr as the new tail
//   busy            responder not idle
// slave  : the responder (ice_echo_int)
// master : the bus controller side driving frames, grant and TX status
interface ice_echo_int_if;
    logic [7:0] ma_data;
    logic [7:0] ma_addr;
    logic       ma_data_valid;
    logic       ma_frame_valid;
    logic       sl_overflow;
    logic [8:0] sl_tail;
    logic       sl_arb_grant;
    logic       sl_arb_request;
    logic [8:0] sl_addr;
    logic [8:0] sl_data;
    logic       sl_latch_tail;
    logic       busy;

    modport slave (
        input  ma_data, ma_addr, ma_data_valid, ma_frame_valid,
        input  sl_overflow, sl_tail, sl_arb_grant,
        output sl_arb_request, sl_addr, sl_data, sl_latch_tail, busy
    );

    modport master (
        output ma_data, ma_addr, ma_data_valid, ma_frame_valid,
        output sl_overflow, sl_tail, sl_arb_grant,
        input  sl_arb_request, sl_addr, sl_data, sl_latch_tail, busy
    );
endinterface

// File: rtl/ice_echo_int.sv
// Echo responder on the ICE internal bus. Captures a master frame whose
// ma_addr equals MSG_TYPE, then arbitrates for the slave bus and writes
// [RESP_TYPE][len][payload] into the controller TX buffer starting at the
// tail sampled at grant, finishing with a one-cycle tail latch.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    ice_echo_int_if.slave (master frame in, TX buffer write port out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for the rising edge of a MSG_TYPE frame
// S_CAPTURE  | storing payload bytes into the capture buffer
// S_DROP     | frame exceeded DEPTH; discard until the frame ends
// S_REQ      | requesting the slave bus, waiting for grant
// S_HDR_TYPE | writing RESP_TYPE at base
// S_HDR_LEN  | writing the payload length at base+1
// S_PAYLOAD  | writing captured byte k at base+2+k
// S_LATCH    | committing base+2+len as the new tail
module ice_echo_int #(
    parameter logic [7:0] MSG_TYPE  = 8'h65,
    parameter logic [7:0] RESP_TYPE = 8'h45,
    parameter int         DEPTH     = 64
) (
    input  logic          clk,
    input  logic          reset,
    ice_echo_int_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_DROP, S_REQ,
        S_HDR_TYPE, S_HDR_LEN, S_PAYLOAD, S_LATCH
    } state_t;

    state_t     state, state_d;
    logic       fv_q;
    logic [7:0] cnt;
    logic [7:0] k;
    logic [8:0] base;
    logic [7:0] cap_mem [DEPTH];

    logic          rise, fall, hit, full, store, abort;
    logic [AW-1:0] wr_idx;
    logic          req_c, latch_c;
    logic [8:0]    addr_c, data_c;

    assign rise  = bus.ma_frame_valid & ~fv_q;
    assign fall  = ~bus.ma_frame_valid & fv_q;
    assign hit   = rise && (bus.ma_addr == MSG_TYPE);
    assign full  = (cnt == 8'(DEPTH));
    // The strobe on the rising-edge cycle belongs to the frame and lands at index 0.
    assign store = bus.ma_data_valid &&
                   (((state == S_IDLE) && hit) || ((state == S_CAPTURE) && !full));
    assign wr_idx = (state == S_IDLE) ? '0 : cnt[AW-1:0];
    // Losing the grant mid-write is handled exactly like a full TX buffer.
    assign abort = ((state == S_HDR_TYPE) || (state == S_HDR_LEN) || (state == S_PAYLOAD)) &&
                   (bus.sl_overflow || !bus.sl_arb_grant);

    always_comb begin
        state_d = state;
        req_c   = 1'b0;
        addr_c  = '0;
        data_c  = '0;
        latch_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (hit) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Overflow strobe wins; a coincident frame end skips DROP entirely.
                if (bus.ma_data_valid && full) state_d = fall ? S_IDLE : S_DROP;
                else if (fall)                 state_d = S_REQ;
            end
            S_DROP: begin
                if (fall) state_d = S_IDLE;
            end
            S_REQ: begin
                req_c = 1'b1;
                if (bus.sl_arb_grant) state_d = S_HDR_TYPE;
            end
            S_HDR_TYPE: begin
                req_c   = 1'b1;
                addr_c  = base;
                data_c  = {1'b1, RESP_TYPE};
                state_d = S_HDR_LEN;
            end
            S_HDR_LEN: begin
                req_c   = 1'b1;
                addr_c  = base + 9'd1;
                data_c  = {1'b1, cnt};
                state_d = (cnt == 8'd0) ? S_LATCH : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                req_c  = 1'b1;
                addr_c = base + 9'd2 + {1'b0, k};
                data_c = {1'b1, cap_mem[k[AW-1:0]]};
                if (k == cnt - 8'd1) state_d = S_LATCH;
            end
            S_LATCH: begin
                req_c   = 1'b1;
                addr_c  = base + 9'd2 + {1'b0, cnt};
                latch_c = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            req_c   = 1'b0;
            data_c  = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            fv_q  <= 1'b0;
            cnt   <= '0;
            k     <= '0;
            base  <= '0;
        end else begin
            state <= state_d;
            fv_q  <= bus.ma_frame_valid;
            if ((state == S_IDLE) && hit)
                cnt <= bus.ma_data_valid ? 8'd1 : 8'd0;
            else if (store)
                cnt <= cnt + 8'd1;
            if ((state == S_REQ) && bus.sl_arb_grant) begin
                base <= bus.sl_tail;
                k    <= '0;
            end else if (state == S_PAYLOAD) begin
                k <= k + 8'd1;
            end
        end
    end

    // Payload storage needs no reset: only entries below cnt are ever read.
    always_ff @(posedge clk) begin
        if (store) cap_mem[wr_idx] <= bus.ma_data;
    end

    // Wired-OR slave bus: drive nothing without the grant.
    assign bus.sl_arb_request = req_c;
    assign bus.sl_addr        = bus.sl_arb_grant ? addr_c : '0;
    assign bus.sl_data        = bus.sl_arb_grant ? data_c : '0;
    assign bus.sl_latch_tail  = bus.sl_arb_grant & latch_c;
    assign bus.busy           = (state != S_IDLE);

endmodule

// File: tb/tb_ice_echo_int.sv
module tb_ice_echo_int;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ice_echo_int_if bus();
    ice_echo_int dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    string cur_tag = "init";

    logic [7:0]  frame_q[$];
    logic [16:0] got_w[$];
    logic [8:0]  got_l[$];
    logic [16:0] exp_w[$];
    logic [8:0]  exp_l[$];
    bit busy_seen, req_seen;
    int wor_viol = 0;

    typedef struct {
        logic [7:0] addr;
        int         n;
        logic [7:0] first;
        logic [8:0] tail;
        int         abort_w;
        bit         exp_req;
        bit         exp_busy;
        int         exp_nw;
        bit         exp_latch;
        logic [8:0] exp_laddr;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h want %0h", cur_tag, name, act, exp);
        end
    endtask

    // Bus monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.busy) busy_seen = 1;
        if (bus.sl_arb_request) req_seen = 1;
        if (bus.sl_data[8]) got_w.push_back({bus.sl_addr, bus.sl_data[7:0]});
        if (bus.sl_latch_tail) got_l.push_back(bus.sl_addr);
        if (!bus.sl_arb_grant && (bus.sl_addr != 0 || bus.sl_data != 0 || bus.sl_latch_tail))
            wor_viol++;
    end

    // Reference: the response is the byte stream [45][len][payload] laid at
    // consecutive addresses mod 512 from the tail; an abort truncates the stream
    // at the aborted write and suppresses the latch.
    task automatic model(input logic [7:0] a, input logic [8:0] tail, input int abort_w);
        logic [7:0] stream[$];
        int nw;
        exp_w.delete();
        exp_l.delete();
        if (a == 8'h65 && frame_q.size() <= 64) begin
            stream.push_back(8'h45);
            stream.push_back(8'(frame_q.size()));
            foreach (frame_q[i]) stream.push_back(frame_q[i]);
            nw = (abort_w >= 0) ? abort_w : stream.size();
            for (int i = 0; i < nw; i++) exp_w.push_back({9'(tail + i), stream[i]});
            if (abort_w < 0) exp_l.push_back(9'(tail + stream.size()));
        end
    endtask

    task automatic cyc(input logic fv, input logic dv, input logic [7:0] d, input logic [7:0] a);
        @(posedge clk); #1;
        bus.ma_frame_valid = fv;
        bus.ma_data_valid  = dv;
        bus.ma_data        = d;
        bus.ma_addr        = a;
    endtask

    task automatic send_frame(input logic [7:0] a, input int gap_max, input bit coincide);
        int n = frame_q.size();
        int last = (coincide && n > 0) ? n - 1 : n;
        for (int i = 0; i < last; i++) begin
            repeat ($urandom_range(0, gap_max)) cyc(1, 0, 8'h00, a);
            cyc(1, 1, frame_q[i], a);
        end
        if (last == 0) cyc(1, 0, 8'h00, a);
        if (coincide && n > 0) cyc(0, 1, frame_q[n-1], a);
        else                   cyc(0, 0, 8'h00, a);
    endtask

    task automatic serve(input int gdelay, input int abort_w, input bit by_grant, input bit exp_req);
        int waited = 0, idx = -1, cyc_n = 0;
        bit done = 0, granted = 0, ab_prev = 0;
        while (!done) begin
            @(posedge clk); #1;
            bus.ma_frame_valid = 0;
            bus.ma_data_valid  = 0;
            bus.sl_overflow    = 0;
            cyc_n++;
            if (ab_prev) begin
                chk("abort_busy", bus.busy, 0);
                chk("abort_req", bus.sl_arb_request, 0);
                ab_prev = 0;
            end
            if (granted) idx++;
            if (granted && !bus.busy) done = 1;
            else if (!granted && !exp_req && cyc_n >= 8) done = 1;
            else if (cyc_n > 400) begin
                chk("timeout", cyc_n, 0);
                done = 1;
            end else begin
                if (bus.sl_arb_request && !granted) begin
                    if (waited >= gdelay) begin granted = 1; idx = 0; end
                    else waited++;
                end
                bus.sl_arb_grant = granted;
                if (granted && abort_w >= 0 && idx == abort_w + 1) begin
                    if (by_grant) bus.sl_arb_grant = 0;
                    else          bus.sl_overflow  = 1;
                    ab_prev = 1;
                    #1 chk("abort_we", bus.sl_data[8], 0);
                end
            end
        end
        bus.sl_arb_grant = 0;
        bus.sl_overflow  = 0;
    endtask

    task automatic scoreboard();
        int m = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        chk("n_writes", got_w.size(), exp_w.size());
        for (int i = 0; i < m; i++) chk("write", got_w[i], exp_w[i]);
        chk("n_latch", got_l.size(), exp_l.size());
        if (got_l.size() > 0 && exp_l.size() > 0) chk("latch_addr", got_l[0], exp_l[0]);
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [8:0] tail, input int gdelay,
                            input int abort_w, input bit by_grant, input bit exp_req,
                            input int gap_max, input bit coincide);
        got_w.delete();
        got_l.delete();
        busy_seen = 0;
        req_seen  = 0;
        bus.sl_tail = tail;
        send_frame(a, gap_max, coincide);
        serve(gdelay, abort_w, by_grant, exp_req);
        model(a, tail, abort_w);
        scoreboard();
    endtask

    initial begin
        bus.ma_data = 0; bus.ma_addr = 0; bus.ma_data_valid = 0; bus.ma_frame_valid = 0;
        bus.sl_overflow = 0; bus.sl_tail = 0; bus.sl_arb_grant = 0;

        vecs[0] = '{8'h65,  3, 8'h01, 9'h010, -1, 1, 1,  5, 1, 9'h015};
        vecs[1] = '{8'h66,  2, 8'hAA, 9'h020, -1, 0, 0,  0, 0, 9'h000};
        vecs[2] = '{8'h65,  0, 8'h00, 9'h1FE, -1, 1, 1,  2, 1, 9'h000};
        vecs[3] = '{8'h65, 65, 8'h00, 9'h030, -1, 0, 1,  0, 0, 9'h000};
        vecs[4] = '{8'h65,  1, 8'h5A, 9'h100, -1, 1, 1,  3, 1, 9'h103};
        vecs[5] = '{8'h65,  4, 8'hC0, 9'h020,  3, 1, 1,  3, 0, 9'h000};
        vecs[6] = '{8'h65, 64, 8'h80, 9'h1F0, -1, 1, 1, 66, 1, 9'h032};

        #3;
        cur_tag = "reset";
        chk("req", bus.sl_arb_request, 0);
        chk("addr", bus.sl_addr, 0);
        chk("data", bus.sl_data, 0);
        chk("latch", bus.sl_latch_tail, 0);
        chk("busy", bus.busy, 0);
        @(posedge clk); #1 reset = 0;
        repeat (2) @(posedge clk);

        foreach (vecs[v]) begin
            cur_tag = $sformatf("vec%0d", v);
            frame_q.delete();
            for (int i = 0; i < vecs[v].n; i++) frame_q.push_back(8'(vecs[v].first + i));
            do_frame(vecs[v].addr, vecs[v].tail, 0, vecs[v].abort_w, 0, vecs[v].exp_req, 0, 0);
            chk("req_seen", req_seen, vecs[v].exp_req);
            chk("busy_seen", busy_seen, vecs[v].exp_busy);
            chk("nw_table", got_w.size(), vecs[v].exp_nw);
            chk("latch_table", got_l.size(), vecs[v].exp_latch);
            if (vecs[v].exp_latch && got_l.size() > 0) chk("laddr_table", got_l[0], vecs[v].exp_laddr);
        end

        // Byte coincident with the frame end is kept.
        cur_tag = "coincide";
        frame_q = {8'h31, 8'h32};
        do_frame(8'h65, 9'h1FF, 2, -1, 0, 1, 0, 1);

        // Grant withdrawn during the length write.
        cur_tag = "grant_loss";
        frame_q = {8'h09, 8'h08};
        do_frame(8'h65, 9'h040, 1, 1, 1, 1, 0, 0);

        // Asynchronous reset while writing payload.
        cur_tag = "reset_mid";
        frame_q = {8'h11, 8'h12, 8'h13, 8'h14};
        got_w.delete();
        got_l.delete();
        bus.sl_tail = 9'h080;
        send_frame(8'h65, 0, 0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            bus.ma_data_valid = 0;
            bus.sl_arb_grant = bus.sl_arb_request;
            if (got_w.size() >= 3) break;
        end
        #2 reset = 1;
        #1;
        chk("req", bus.sl_arb_request, 0);
        chk("addr", bus.sl_addr, 0);
        chk("data", bus.sl_data, 0);
        chk("latch", bus.sl_latch_tail, 0);
        chk("busy", bus.busy, 0);
        bus.sl_arb_grant = 0;
        @(posedge clk); #1 reset = 0;
        repeat (4) @(posedge clk);
        chk("writes_before_rst", got_w.size(), 3);
        chk("no_latch", got_l.size(), 0);
        cur_tag = "after_reset";
        frame_q = {8'h77};
        do_frame(8'h65, 9'h050, 0, -1, 0, 1, 0, 0);

        // Randomized frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] a;
            int n, aw, gd;
            cur_tag = $sformatf("rand%0d", r);
            a  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h65;
            n  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 20);
            aw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n + 1) : -1;
            gd = $urandom_range(0, 4);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
            do_frame(a, 9'($urandom), gd, aw, 1'($urandom_range(0, 1)),
                     (a == 8'h65 && n <= 64), 2, 1'($urandom_range(0, 1)));
        end

        cur_tag = "bus";
        chk("wired_or", wor_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
